// File: rtl/sap1_display.sv
// SAP-1 output display: double-dabble BCD conversion plus 4-digit multiplexed 7-segment scan.
// Optional macro SAP1_DISP_SIGNED_EN: treat value as two's complement and show a minus sign.
module sap1_display #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [11:0] bcd,
    output logic        busy
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t        state;
    logic [7:0]    shown, cap, mag;
    logic [11:0]   work;
    logic [2:0]    cnt;
    logic          neg, cap_neg;
    logic [PW-1:0] pre;
    logic [1:0]    idx, nidx;
    logic          in_neg;
    logic [7:0]    in_mag;
    logic [11:0]   adj;
    logic [19:0]   shifted;
    logic [6:0]    seg_nxt;

`ifdef SAP1_DISP_SIGNED_EN
    assign in_neg = value[7];
    assign in_mag = value[7] ? 8'(-value) : value;
`else
    assign in_neg = 1'b0;
    assign in_mag = value;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b1000000;
            4'd1: seg_of = 7'b1111001;
            4'd2: seg_of = 7'b0100100;
            4'd3: seg_of = 7'b0110000;
            4'd4: seg_of = 7'b0011001;
            4'd5: seg_of = 7'b0010010;
            4'd6: seg_of = 7'b0000010;
            4'd7: seg_of = 7'b1111000;
            4'd8: seg_of = 7'b0000000;
            4'd9: seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction applied before each shift so every nibble stays a valid BCD digit.
    always_comb begin
        adj = work;
        for (int i = 0; i < 3; i++)
            if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        shifted = {adj, mag} << 1;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= IDLE;
            shown   <= '0;
            cap     <= '0;
            cap_neg <= 1'b0;
            mag     <= '0;
            work    <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            bcd     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (value != shown) begin
                    cap     <= value;
                    cap_neg <= in_neg;
                    mag     <= in_mag;
                    work    <= '0;
                    cnt     <= '0;
                    busy    <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    {work, mag} <= shifted;
                    cnt         <= cnt + 3'd1;
                    if (cnt == 3'd7) state <= COMMIT;
                end
                COMMIT: begin
                    bcd   <= work;
                    shown <= cap;
                    neg   <= cap_neg;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The index advances before loading, so the pattern is for the digit about to be lit.
    assign nidx = idx + 2'd1;

    always_comb begin
        seg_nxt = SEG_BLANK;
        case (nidx)
            2'd0: seg_nxt = seg_of(bcd[3:0]);
            2'd1: seg_nxt = (BLANK_LZ != 0 && bcd[11:4] == 8'h00) ? SEG_BLANK : seg_of(bcd[7:4]);
            2'd2: seg_nxt = (BLANK_LZ != 0 && bcd[11:8] == 4'h0) ? SEG_BLANK : seg_of(bcd[11:8]);
            2'd3: seg_nxt = neg ? SEG_MINUS : SEG_BLANK;
            default: seg_nxt = SEG_BLANK;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            pre <= '0;
            idx <= '0;
            seg <= SEG_BLANK;
            an  <= 4'b1111;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= nidx;
            seg <= seg_nxt;
            an  <= ~(4'b0001 << nidx);
        end else begin
            pre <= pre + 1'b1;
        end
    end
endmodule

// File: tb/tb_sap1_display.sv
// Directed bench for sap1_display with a short scan period (SCAN_DIV=4).
module tb_sap1_display;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010, S8 = 7'b0000000;
    localparam logic [6:0] SM = 7'b0111111, SB = 7'b1111111;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  value  = 8'd0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [11:0] bcd;
    logic        busy;

    int passed = 0;
    int total  = 0;

    sap1_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .sysclk(sysclk), .reset(reset), .value(value),
        .seg(seg), .an(an), .bcd(bcd), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Sample a full scan after letting every digit refresh; returns the segments per digit.
    task automatic capture_scan(output logic [6:0] s0, output logic [6:0] s1,
                                output logic [6:0] s2, output logic [6:0] s3,
                                output int bad_an);
        s0 = 'x; s1 = 'x; s2 = 'x; s3 = 'x; bad_an = 0;
        repeat (16) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            case (an)
                4'b1110: s0 = seg;
                4'b1101: s1 = seg;
                4'b1011: s2 = seg;
                4'b0111: s3 = seg;
                default: bad_an++;
            endcase
        end
    endtask

    task automatic test_reset();
        int busy_seen = 0;
        reset = 1'b1; value = 8'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
        end
        total++; if (busy_seen !== 0) $display("FAIL reset_busy: %0d cycles high, want 0", busy_seen); else passed++;
        total++; if (seg !== SB) $display("FAIL reset_seg: got %b want %b", seg, SB); else passed++;
        total++; if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an); else passed++;
        total++; if (bcd !== 12'h000) $display("FAIL reset_bcd: got %h want 000", bcd); else passed++;
    endtask

    task automatic test_scan_zero();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int di;
        reset = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e < 4) begin
                exp_an = 4'b1111; exp_seg = SB;
            end else begin
                di = (e / 4) % 4;
                exp_an  = ~(4'b0001 << di);
                exp_seg = (di == 0) ? S0 : SB;
            end
            total++; if (an !== exp_an) $display("FAIL scan_an e=%0d: got %b want %b", e, an, exp_an); else passed++;
            total++; if (seg !== exp_seg) $display("FAIL scan_seg e=%0d: got %b want %b", e, seg, exp_seg); else passed++;
        end
        total++; if (busy !== 1'b0) $display("FAIL scan_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_convert_255();
        int hi = 0;
        logic [6:0] s0, s1, s2, s3;
        int bad;
        value = 8'd255;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (busy === 1'b1) hi++;
            if (j == 8) begin
                total++; if (bcd !== 12'h000) $display("FAIL c255_precommit: got %h want 000", bcd); else passed++;
            end
            if (j == 9) begin
                total++; if (bcd !== 12'h255) $display("FAIL c255_bcd: got %h want 255", bcd); else passed++;
                total++; if (busy !== 1'b0) $display("FAIL c255_busy_low: got %b want 0", busy); else passed++;
            end
        end
        total++; if (hi !== 9) $display("FAIL c255_busy_len: got %0d want 9", hi); else passed++;
        capture_scan(s0, s1, s2, s3, bad);
        total++; if (bad !== 0) $display("FAIL c255_an_onehot: got %0d bad want 0", bad); else passed++;
        total++; if ({s3, s2, s1, s0} !== {SB, S2, S5, S5})
            $display("FAIL c255_segs: got %b %b %b %b want %b %b %b %b", s3, s2, s1, s0, SB, S2, S5, S5);
        else passed++;
    endtask

    task automatic test_signed_cases();
        logic [6:0] s0, s1, s2, s3, exp_sign;
        logic [11:0] exp_ff;
        int bad;
`ifdef SAP1_DISP_SIGNED_EN
        exp_sign = SM; exp_ff = 12'h001;
`else
        exp_sign = SB; exp_ff = 12'h255;
`endif
        value = 8'h80;
        repeat (12) tick();
        total++; if (bcd !== 12'h128) $display("FAIL c80_bcd: got %h want 128", bcd); else passed++;
        capture_scan(s0, s1, s2, s3, bad);
        total++; if ({s3, s2, s1, s0} !== {exp_sign, S1, S2, S8})
            $display("FAIL c80_segs: got %b %b %b %b want %b %b %b %b", s3, s2, s1, s0, exp_sign, S1, S2, S8);
        else passed++;
        value = 8'hFF;
        repeat (12) tick();
        total++; if (bcd !== exp_ff) $display("FAIL cff_bcd: got %h want %h", bcd, exp_ff); else passed++;
`ifdef SAP1_DISP_SIGNED_EN
        capture_scan(s0, s1, s2, s3, bad);
        total++; if ({s3, s2, s1, s0} !== {SM, SB, SB, S1})
            $display("FAIL cff_segs: got %b %b %b %b want %b %b %b %b", s3, s2, s1, s0, SM, SB, SB, S1);
        else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [21:0] seen, expv;
        seen = '0;
        expv = '0;
        for (int j = 0; j <= 8; j++)   expv[j] = 1'b1;
        for (int j = 10; j <= 18; j++) expv[j] = 1'b1;
        value = 8'd7;
        for (int j = 0; j < 22; j++) begin
            tick();
            seen[j] = busy;
            if (j == 3) value = 8'd42;
            if (j == 9) begin
                total++; if (bcd !== 12'h007) $display("FAIL b2b_first: got %h want 007", bcd); else passed++;
            end
            if (j == 19) begin
                total++; if (bcd !== 12'h042) $display("FAIL b2b_second: got %h want 042", bcd); else passed++;
            end
        end
        total++; if (seen !== expv) $display("FAIL b2b_busy: got %b want %b", seen, expv); else passed++;
    endtask

    task automatic test_reset_mid();
        value = 8'd99;
        repeat (5) tick();   // load plus four shifts
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_pre: got %b want 1", busy); else passed++;
        reset = 1'b1;
        repeat (2) tick();
        total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        total++; if (bcd !== 12'h000) $display("FAIL mid_bcd: got %h want 000", bcd); else passed++;
        total++; if (seg !== SB) $display("FAIL mid_seg: got %b want %b", seg, SB); else passed++;
        total++; if (an !== 4'b1111) $display("FAIL mid_an: got %b want 1111", an); else passed++;
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (j == 0) begin
                total++; if (busy !== 1'b1) $display("FAIL mid_restart: got %b want 1", busy); else passed++;
            end
            if (j == 8) begin
                total++; if (bcd !== 12'h000) $display("FAIL mid_early: got %h want 000", bcd); else passed++;
            end
            if (j == 9) begin
                total++; if (bcd !== 12'h099) $display("FAIL mid_bcd99: got %h want 099", bcd); else passed++;
                total++; if (busy !== 1'b0) $display("FAIL mid_done: got %b want 0", busy); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_zero();
        test_convert_255();
        test_signed_cases();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
